alu_pipe: RTL and testbench

Parametrised, pipelined successor to the team's 4-bit combinational ALU. It adds configurable operand width, an 8-operation set (including shifts, XOR and a running accumulator), signed overflow/negative flags and valid/ready handshakes on input and output. It sits between an operand source (sequencer or test harness) and a result consumer, and can stall in either direction without losing or duplicating operations.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 69 ++++++
 rtl/alu_pipe.sv | 119 +++++++++++
 tb/tb_alu_pipe.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and result flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_ACC = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, carry/borrow and signed overflow for one op.
// Arithmetic is done one bit wider than the operands so the top bit is the carry.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH-1:0] o_y,
    output logic             o_carry,
    output logic             o_ovf
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

    logic [WIDTH:0]   w_sum_ab;
    logic [WIDTH:0]   w_diff_ab;
    logic [WIDTH:0]   w_sum_acc;
    logic [SHW-1:0]   w_shamt;
    logic             w_sh_oor;
    alu_op_e          w_op;

    assign w_sum_ab  = {1'b0, i_a}   + {1'b0, i_b};
    assign w_diff_ab = {1'b0, i_a}   - {1'b0, i_b};
    assign w_sum_acc = {1'b0, i_acc} + {1'b0, i_a};
    assign w_shamt   = i_b[SHW-1:0];
    // Any shift of WIDTH or more clears the result, including large b with high bits set.
    assign w_sh_oor  = (i_b >= W_LIM);
    assign w_op      = alu_op_e'(i_op);

    // Opcode decode: select result and arithmetic flags; non-arithmetic ops leave flags at 0.
    always_comb begin
        o_y     = '0;
        o_carry = 1'b0;
        o_ovf   = 1'b0;
        case (w_op)
            OP_ADD: begin
                o_y     = w_sum_ab[WIDTH-1:0];
                o_carry = w_sum_ab[WIDTH];
                o_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                          (w_sum_ab[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the widened difference is the unsigned borrow (a < b).
                o_y     = w_diff_ab[WIDTH-1:0];
                o_carry = w_diff_ab[WIDTH];
                o_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                          (w_diff_ab[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: o_y = i_a & i_b;
            OP_OR:  o_y = i_a | i_b;
            OP_XOR: o_y = i_a ^ i_b;
            OP_SHL: o_y = w_sh_oor ? '0 : (i_a << w_shamt);
            OP_SHR: o_y = w_sh_oor ? '0 : (i_a >> w_shamt);
            OP_ACC: begin
                o_y     = w_sum_acc[WIDTH-1:0];
                o_carry = w_sum_acc[WIDTH];
                o_ovf   = (i_acc[WIDTH-1] == i_a[WIDTH-1]) &&
                          (w_sum_acc[WIDTH-1] != i_acc[WIDTH-1]);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and a running accumulator.
// S1 holds the accepted operands, S2 holds the registered result and flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic [WIDTH-1:0] acc_q
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    alu_op_e          r_s1_op;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_carry;
    logic             r_ovf;
    logic [WIDTH-1:0] r_acc;

    logic             w_s2_adv;
    logic [WIDTH-1:0] w_y;
    logic             w_carry;
    logic             w_ovf;
    alu_flags_t       w_flags;

    // S2 moves whenever it is empty or its result is being taken; S1 follows S2.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s2_adv;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a     (r_s1_a),
        .i_b     (r_s1_b),
        .i_op    (r_s1_op),
        .i_acc   (r_acc),
        .o_y     (w_y),
        .o_carry (w_carry),
        .o_ovf   (w_ovf)
    );

    // Stage 1: capture operands when the slot is free or draining this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_ADD;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a  <= a;
                r_s1_b  <= b;
                r_s1_op <= alu_op_e'(op);
            end
        end
    end

    // Stage 2: register result/flags; contents hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y     <= w_y;
                r_carry <= w_carry;
                r_ovf   <= w_ovf;
            end
        end
    end

    // Accumulator: commits once per ACC, exactly when that op enters S2, so a following
    // ACC sitting in S1 next cycle already sees the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_s2_adv && r_s1_valid && (r_s1_op == OP_ACC)) begin
            r_acc <= w_y;
        end
    end

    // Flag bundle: zero/neg come straight from the registered result, so reset gives zero=1.
    always_comb begin
        w_flags       = '0;
        w_flags.carry = r_carry;
        w_flags.zero  = (r_y == '0);
        w_flags.neg   = r_y[WIDTH-1];
        w_flags.ovf   = r_ovf;
    end

    assign out_valid = r_s2_valid;
    assign y         = r_y;
    assign carry     = w_flags.carry;
    assign zero      = w_flags.zero;
    assign neg       = w_flags.neg;
    assign ovf       = w_flags.ovf;
    assign acc_q     = r_acc;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed vectors plus a randomized stream
// checked against an integer-arithmetic reference model.
module tb_alu_pipe;

    localparam int W    = 8;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         carry;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic [W-1:0] acc_q;

    int n_tests;
    int n_fail;
    int m_acc;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] y;
        logic       c;
        logic       z;
        logic       n;
        logic       o;
    } vec_t;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .carry     (carry),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .acc_q     (acc_q)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int sgn(input int x);
        return (x >= HALF) ? x - MOD : x;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int ma, input int mb, input int mop, input int macc,
                                  output int ry, output bit rc, output bit ro);
        int r;
        int sr;
        ry = 0; rc = 0; ro = 0;
        case (mop)
            0: begin r = ma + mb; ry = r % MOD; rc = (r >= MOD);
                     sr = sgn(ma) + sgn(mb); ro = (sr >= HALF) || (sr < -HALF); end
            1: begin ry = (ma - mb + MOD) % MOD; rc = (ma < mb);
                     sr = sgn(ma) - sgn(mb); ro = (sr >= HALF) || (sr < -HALF); end
            2: ry = ma & mb;
            3: ry = ma | mb;
            4: ry = ma ^ mb;
            5: ry = (mb >= W) ? 0 : ((ma << mb) % MOD);
            6: ry = (mb >= W) ? 0 : (ma >> mb);
            default: begin r = macc + ma; ry = r % MOD; rc = (r >= MOD);
                     sr = sgn(macc) + sgn(ma); ro = (sr >= HALF) || (sr < -HALF); end
        endcase
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0;
    endtask

    // Driver: send one op with out_ready=1 and return the emitted result (ok=0 on timeout).
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                         output logic [7:0] ry, output logic rc, output logic rz,
                         output logic rn, output logic ro, output bit ok);
        int t;
        @(negedge clk);
        in_valid = 1'b1; a = ia; b = ib; op = iop; out_ready = 1'b1;
        #1;
        t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin @(negedge clk); t++; end
        ok = out_valid;
        ry = y; rc = carry; rz = zero; rn = neg; ro = ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || y !== 8'h00 || carry !== 1'b0 || ovf !== 1'b0 ||
            neg !== 1'b0 || zero !== 1'b1 || acc_q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: ov=%b y=%h c=%b o=%b n=%b z=%b acc=%h, want 0 00 0 0 0 1 00",
                     out_valid, y, carry, ovf, neg, zero, acc_q);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_sub();
        vec_t v[4];
        logic [7:0] ry; logic rc, rz, rn, ro; bit ok;
        v[0] = '{8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        v[1] = '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        v[2] = '{8'h03, 8'h05, 3'd1, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
        v[3] = '{8'h80, 8'h01, 3'd1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_op(v[i].a, v[i].b, v[i].op, ry, rc, rz, rn, ro, ok);
            n_tests++;
            if (!ok || ry !== v[i].y || rc !== v[i].c || rz !== v[i].z ||
                rn !== v[i].n || ro !== v[i].o) begin
                n_fail++;
                $display("FAIL add_sub[%0d]: ok=%b y=%h c=%b z=%b n=%b o=%b, want y=%h c=%b z=%b n=%b o=%b",
                         i, ok, ry, rc, rz, rn, ro, v[i].y, v[i].c, v[i].z, v[i].n, v[i].o);
            end
        end
    endtask

    task automatic test_shift_logic();
        vec_t v[7];
        logic [7:0] ry; logic rc, rz, rn, ro; bit ok;
        v[0] = '{8'h81, 8'd1,  3'd5, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        v[1] = '{8'h80, 8'd7,  3'd6, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        v[2] = '{8'hFF, 8'd8,  3'd5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        v[3] = '{8'hFF, 8'h10, 3'd6, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        v[4] = '{8'hAA, 8'hFF, 3'd4, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
        v[5] = '{8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        v[6] = '{8'h0F, 8'hF0, 3'd3, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            do_op(v[i].a, v[i].b, v[i].op, ry, rc, rz, rn, ro, ok);
            n_tests++;
            if (!ok || ry !== v[i].y || rc !== v[i].c || rz !== v[i].z ||
                rn !== v[i].n || ro !== v[i].o) begin
                n_fail++;
                $display("FAIL shift_logic[%0d]: ok=%b y=%h c=%b z=%b n=%b o=%b, want y=%h c=%b z=%b n=%b o=%b",
                         i, ok, ry, rc, rz, rn, ro, v[i].y, v[i].c, v[i].z, v[i].n, v[i].o);
            end
        end
    endtask

    task automatic test_acc();
        logic [7:0] ain[3];
        logic [7:0] yexp[3];
        logic       cexp[3];
        logic [7:0] ry; logic rc, rz, rn, ro; bit ok;
        ain[0] = 8'd5;   yexp[0] = 8'd5;  cexp[0] = 1'b0;
        ain[1] = 8'd10;  yexp[1] = 8'd15; cexp[1] = 1'b0;
        ain[2] = 8'd250; yexp[2] = 8'd9;  cexp[2] = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_op(ain[i], 8'h00, 3'd7, ry, rc, rz, rn, ro, ok);
            n_tests++;
            if (!ok || ry !== yexp[i] || rc !== cexp[i] || ro !== 1'b0) begin
                n_fail++;
                $display("FAIL acc[%0d]: ok=%b y=%0d c=%b o=%b, want y=%0d c=%b o=0",
                         i, ok, ry, rc, ro, yexp[i], cexp[i]);
            end
        end
        n_tests++;
        if (acc_q !== 8'd9) begin
            n_fail++;
            $display("FAIL acc_q: got %0d want 9", acc_q);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] qa[6];
        logic [7:0] qb[6];
        int         exp_y[$];
        int         got_y[$];
        int         idx;
        bit         stalled;
        logic [7:0] held;
        idx = 0; stalled = 0; held = '0;
        for (int i = 0; i < 6; i++) begin
            qa[i] = 8'($urandom); qb[i] = 8'($urandom);
            exp_y.push_back((int'(qa[i]) + int'(qb[i])) % MOD);
        end
        for (int cyc = 0; cyc < 40 && got_y.size() < 6; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                n_tests++;
                if (out_valid !== 1'b1 || y !== held) begin
                    n_fail++;
                    $display("FAIL bp_stable: ov=%b y=%h, want ov=1 y=%h", out_valid, y, held);
                end
            end
            out_ready = (cyc >= 4);
            in_valid  = (idx < 6);
            if (idx < 6) begin a = qa[idx]; b = qb[idx]; op = 3'd0; end
            #1;
            if (cyc == 2) begin
                n_tests++;
                if (in_ready !== 1'b0 || idx != 2) begin
                    n_fail++;
                    $display("FAIL bp_full: in_ready=%b accepts=%0d, want 0 after 2", in_ready, idx);
                end
            end
            if (out_valid && out_ready) got_y.push_back(int'(y));
            stalled = out_valid && !out_ready;
            held    = y;
            if (in_valid && in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (got_y.size() != 6) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results want 6", got_y.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (got_y[i] != exp_y[i]) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: y=%h want %h", i, got_y[i], exp_y[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ry; logic rc, rz, rn, ro; bit ok;
        int  accepts;
        int  t;
        bit  spurious;
        do_reset();
        do_op(8'h33, 8'h00, 3'd7, ry, rc, rz, rn, ro, ok);
        accepts = 0; t = 0;
        while (accepts < 2 && t < 10) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'd0; out_ready = 1'b0;
            #1;
            if (in_ready) accepts++;
            t++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_q !== 8'h33) begin
            n_fail++;
            $display("FAIL rst_mid_full: ov=%b ir=%b acc=%h, want 1 0 33", out_valid, in_ready, acc_q);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || acc_q !== 8'h00 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_clear: ov=%b acc=%h z=%b, want 0 00 1", out_valid, acc_q, zero);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; m_acc = 0;
        spurious = 0;
        repeat (3) begin @(negedge clk); if (out_valid) spurious = 1; end
        n_tests++;
        if (spurious) begin
            n_fail++;
            $display("FAIL rst_mid_stale: out_valid seen after reset, want none");
        end
        do_op(8'h01, 8'h00, 3'd7, ry, rc, rz, rn, ro, ok);
        n_tests++;
        if (!ok || ry !== 8'h01) begin
            n_fail++;
            $display("FAIL rst_mid_acc: ok=%b y=%h want 01", ok, ry);
        end
    endtask

    task automatic test_throughput();
        int ey[$];
        bit ec[$];
        bit eo[$];
        int sent, got, first_acc, first_out, stalls;
        int ry; bit rc, ro;
        int ev; bit ecv, eov;
        logic [7:0] ra, rb; logic [2:0] rop;
        do_reset();
        sent = 0; got = 0; first_acc = -1; first_out = -1; stalls = 0;
        for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                n_tests++;
                if (ey.size() == 0) begin
                    n_fail++;
                    $display("FAIL tp_spurious: result y=%h with none expected", y);
                end else begin
                    ev = ey.pop_front(); ecv = ec.pop_front(); eov = eo.pop_front();
                    if (int'(y) != ev || carry !== ecv || ovf !== eov ||
                        zero !== (ev == 0) || neg !== (ev >= HALF)) begin
                        n_fail++;
                        $display("FAIL tp_result[%0d]: y=%h c=%b o=%b z=%b n=%b, want y=%h c=%b o=%b",
                                 got, y, carry, ovf, zero, neg, ev, ecv, eov);
                    end
                end
                got++;
            end
            out_ready = 1'b1;
            if (sent < 100) begin
                ra  = 8'($urandom);
                rop = 3'($urandom);
                rb  = ($urandom % 2) ? 8'($urandom % 9) : 8'($urandom);
                in_valid = 1'b1; a = ra; b = rb; op = rop;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                model(int'(ra), int'(rb), int'(rop), m_acc, ry, rc, ro);
                if (rop == 3'd7) m_acc = ry;
                ey.push_back(ry); ec.push_back(rc); eo.push_back(ro);
                sent++;
            end else if (in_valid) begin
                stalls++;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 100 || sent != 100) begin
            n_fail++;
            $display("FAIL tp_count: sent=%0d got=%0d want 100/100", sent, got);
        end
        n_tests++;
        if (first_out - first_acc != 2) begin
            n_fail++;
            $display("FAIL tp_latency: %0d cycles want 2", first_out - first_acc);
        end
        n_tests++;
        if (stalls != 0) begin
            n_fail++;
            $display("FAIL tp_stall: in_ready low %0d cycles want 0", stalls);
        end
        n_tests++;
        if (int'(acc_q) != m_acc) begin
            n_fail++;
            $display("FAIL tp_acc_q: got %h want %h", acc_q, m_acc);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; m_acc = 0;
        test_reset();
        test_add_sub();
        test_shift_logic();
        test_acc();
        test_backpressure();
        test_reset_mid();
        test_throughput();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
